// File: rtl/axi4s_pkt_gen_if.sv
// AXI4-Stream data channel between a packet source (master) and a sink (slave).
interface axi4s_pkt_gen_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi4s_pkt_gen.sv
// AXI4-Stream burst packet generator; optional idle gap between packets via AXI4S_PKT_GEN_GAP_EN.
// First beat one cycle after start; all outputs registered and held stable while m.tready is low.
module axi4s_pkt_gen #(
  parameter int DW   = 32,
  parameter int LENW = 16,
  parameter int NUMW = 8,
  parameter int GAP  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [LENW-1:0] pkt_len,
  input  logic [NUMW-1:0] pkt_num,
  output logic            busy,
  output logic            done,
  axi4s_pkt_gen_if.master m
);

  if (GAP < 1) begin : g_gap_chk
    $error("axi4s_pkt_gen: GAP must be at least 1");
  end

`ifdef AXI4S_PKT_GEN_GAP_EN
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP_ST = 2'd2} state_t;
  logic [GW-1:0]   gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t          state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [NUMW-1:0] num_q, num_d;
  logic [LENW-1:0] beat_q, beat_d;
  logic [NUMW-1:0] pkt_q, pkt_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      num_q    <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef AXI4S_PKT_GEN_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      num_q    <= num_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef AXI4S_PKT_GEN_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  // tdata_q doubles as the word counter: each new beat presents the previous word + 1.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    num_d    = num_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef AXI4S_PKT_GEN_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      IDLE: begin
        // done_q marks the completion cycle, in which a new start is not taken
        if (start && !done_q) begin
          state_d  = SEND;
          len_d    = pkt_len;
          num_d    = pkt_num;
          beat_d   = '0;
          pkt_d    = '0;
          tdata_d  = '0;
          tvalid_d = 1'b1;
          tlast_d  = (pkt_len == '0);
          busy_d   = 1'b1;
        end
      end
      SEND: begin
        if (tvalid_q && m.tready) begin
          if (tlast_q) begin
            if (pkt_q == num_q) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              pkt_d  = pkt_q + 1'b1;
              beat_d = '0;
`ifdef AXI4S_PKT_GEN_GAP_EN
              state_d  = GAP_ST;
              tvalid_d = 1'b0;
              gap_d    = GW'(GAP - 1);
`else
              tdata_d = tdata_q + 1'b1;
              tlast_d = (len_q == '0);
`endif
            end
          end else begin
            beat_d  = beat_q + 1'b1;
            tdata_d = tdata_q + 1'b1;
            tlast_d = (LENW'(beat_q + 1'b1) == len_q);
          end
        end
      end
`ifdef AXI4S_PKT_GEN_GAP_EN
      GAP_ST: begin
        if (gap_q == '0) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
          tdata_d  = tdata_q + 1'b1;
          tlast_d  = (len_q == '0);
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign m.tdata  = tdata_q;
  assign m.tvalid = tvalid_q;
  assign m.tlast  = tlast_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_axi4s_pkt_gen.sv
// Bench for axi4s_pkt_gen: scoreboard of expected beats, stall-stability and burst-timing checks.
module tb_axi4s_pkt_gen;

`ifdef AXI4S_PKT_GEN_GAP_EN
  localparam int EXP_GAP = 4;
`else
  localparam int EXP_GAP = 0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] pkt_len;
  logic [7:0]  pkt_num;
  logic        busy;
  logic        done;

  int    checks;
  int    errors;
  int    low_cnt;
  int    done_cnt;
  bit    mon_en;
  bit    rnd_rdy;
  bit    prev_stall;
  logic [31:0] prev_d;
  logic        prev_l;
  beat_t sb[$];

  axi4s_pkt_gen_if #(.DW(32)) s_if ();

  axi4s_pkt_gen #(.DW(32), .LENW(16), .NUMW(8), .GAP(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .pkt_len (pkt_len),
    .pkt_num (pkt_num),
    .busy    (busy),
    .done    (done),
    .m       (s_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sink ready changes 2 time units after each rising edge.
  initial begin
    s_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      s_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Values sampled on the falling edge are what the next rising edge will see.
  always @(negedge clk) begin
    beat_t e;
    if (busy && !s_if.tvalid) low_cnt++;
    if (done) done_cnt++;
    if (!mon_en || !reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", s_if.tvalid, 1);
        chk("stall_data_hold", s_if.tdata, prev_d);
        chk("stall_last_hold", s_if.tlast, prev_l);
      end
      if (s_if.tvalid && s_if.tready) begin
        chk("beat_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("tdata", s_if.tdata, e.d);
          chk("tlast", s_if.tlast, e.l);
        end
      end
      prev_stall = s_if.tvalid && !s_if.tready;
      prev_d     = s_if.tdata;
      prev_l     = s_if.tlast;
    end
  end

  task automatic push_burst(input int len, input int num);
    int w;
    w = 0;
    for (int p = 0; p <= num; p++)
      for (int b = 0; b <= len; b++) begin
        sb.push_back({32'(w), (b == len)});
        w++;
      end
  endtask

  task automatic pulse_start(input int len, input int num);
    @(negedge clk);
    start   = 1'b1;
    pkt_len = 16'(len);
    pkt_num = 8'(num);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_burst(input int len, input int num, input bit rnd, input bit poke_done);
    int busy_cyc;
    int low0;
    bit got;
    rnd_rdy = rnd;
    push_burst(len, num);
    low0 = low_cnt;
    pulse_start(len, num);
    busy_cyc = 0;
    got = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
    end
    chk("done_seen", got, 1);
    chk("done_busy_low", busy, 0);
    chk("done_tvalid_low", s_if.tvalid, 0);
    chk("done_tlast_low", s_if.tlast, 0);
    chk("sb_drained", sb.size(), 0);
    if (!rnd) chk("busy_cycles", busy_cyc, (num + 1) * (len + 1) + num * EXP_GAP);
    chk("gap_cycles", low_cnt - low0, num * EXP_GAP);
    if (poke_done) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("start_in_done_busy", busy, 0);
      chk("start_in_done_tvalid", s_if.tvalid, 0);
    end else begin
      @(negedge clk);
      chk("done_pulse_width", done, 0);
    end
  endtask

  task automatic reset_mid_burst();
    int done0;
    rnd_rdy = 1'b0;
    push_burst(7, 1);
    pulse_start(7, 1);
    repeat (3) @(negedge clk);
    // A start during SEND must not restart or shorten the packet.
    pulse_start(0, 0);
    @(negedge clk);
    done0 = done_cnt;
    @(negedge clk);
    mon_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_tvalid", s_if.tvalid, 0);
    chk("rst_tlast", s_if.tlast, 0);
    chk("rst_tdata", s_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", done_cnt - done0, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    run_burst(3, 0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    low_cnt  = 0;
    done_cnt = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    pkt_len  = '0;
    pkt_num  = '0;
    mon_en   = 1'b0;
    rnd_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tvalid", s_if.tvalid, 0);
    chk("reset_tlast", s_if.tlast, 0);
    chk("reset_tdata", s_if.tdata, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    run_burst(3, 0, 1'b0, 1'b1);
    run_burst(1, 2, 1'b0, 1'b0);
    run_burst(7, 0, 1'b1, 1'b0);
    run_burst(2, 2, 1'b1, 1'b0);
    run_burst(0, 3, 1'b0, 1'b0);
    reset_mid_burst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
